link_arbiter: RTL and testbench

LINK_ARBITER -- requirements
Module: link_arbiter

---
 rtl/link_arbiter.sv | 154 +++++++++++++++
 tb/tb_link_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/link_arbiter.sv
// Two-source round-robin arbiter driving a four-phase request/ack link to a remote slave,
// with an abandon-on-timeout counter covering the REQ and SEND phases.
module link_arbiter #(
    parameter int unsigned TIMEOUT = 100000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] src_req,
    input  logic [2:0] src_data0,
    input  logic [2:0] src_data1,
    output logic [1:0] grant,
    output logic [1:0] done,
    output logic [1:0] err,
    output logic       request,
    input  logic       ack,
    output logic [2:0] data_out,
    output logic       valid
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SEND,
        RELEASE
    } state_t;

    localparam logic [26:0] CNT_LAST = 27'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        ack_meta_q, ack_meta_d;
    logic        ack_s_q, ack_s_d;
    logic        ready_q, ready_d;
    logic        last_q, last_d;
    logic        served_q, served_d;
    logic [26:0] cnt_q, cnt_d;
    logic        request_q, request_d;
    logic        valid_q, valid_d;
    logic [2:0]  data_out_q, data_out_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  done_q, done_d;
    logic [1:0]  err_q, err_d;
    logic        win;
    logic        expired;

    // On a tie the source that was not served last wins; a lone requester always wins.
    assign win     = src_req[1] & (~src_req[0] | ~last_q);
    assign expired = (cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        ack_meta_d = ack;
        ack_s_d    = ack_meta_q;
        ready_d    = 1'b1;
        last_d     = last_q;
        served_d   = served_q;
        cnt_d      = cnt_q;
        request_d  = request_q;
        valid_d    = valid_q;
        data_out_d = data_out_q;
        grant_d    = '0;
        done_d     = '0;
        err_d      = '0;

        case (state_q)
            IDLE: begin
                // ready_q holds off the very first edge after reset release.
                if (ready_q && (src_req != 2'b00) && !ack_s_q) begin
                    state_d    = REQ;
                    request_d  = 1'b1;
                    grant_d    = win ? 2'b10 : 2'b01;
                    data_out_d = win ? src_data1 : src_data0;
                    cnt_d      = '0;
                    last_d     = win;
                    served_d   = win;
                end
            end
            REQ: begin
                if (ack_s_q) begin
                    state_d   = SEND;
                    request_d = 1'b0;
                    valid_d   = 1'b1;
                    cnt_d     = '0;
                end else if (expired) begin
                    state_d   = IDLE;
                    request_d = 1'b0;
                    valid_d   = 1'b0;
                    err_d     = served_q ? 2'b10 : 2'b01;
                end else begin
                    cnt_d = cnt_q + 27'd1;
                end
            end
            SEND: begin
                if (!ack_s_q) begin
                    state_d = RELEASE;
                    valid_d = 1'b0;
                    done_d  = served_q ? 2'b10 : 2'b01;
                end else if (expired) begin
                    state_d   = IDLE;
                    request_d = 1'b0;
                    valid_d   = 1'b0;
                    err_d     = served_q ? 2'b10 : 2'b01;
                end else begin
                    cnt_d = cnt_q + 27'd1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
            ready_q    <= 1'b0;
            last_q     <= 1'b1;
            served_q   <= 1'b0;
            cnt_q      <= '0;
            request_q  <= 1'b0;
            valid_q    <= 1'b0;
            data_out_q <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            ack_meta_q <= ack_meta_d;
            ack_s_q    <= ack_s_d;
            ready_q    <= ready_d;
            last_q     <= last_d;
            served_q   <= served_d;
            cnt_q      <= cnt_d;
            request_q  <= request_d;
            valid_q    <= valid_d;
            data_out_q <= data_out_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign grant    = grant_q;
    assign done     = done_q;
    assign err      = err_q;
    assign request  = request_q;
    assign valid    = valid_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_link_arbiter.sv
// Scoreboard bench for link_arbiter: expected grant/done/err events are queued with the stimulus
// and popped as the DUT pulses them; a behavioural slave answers the link.
module tb_link_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] src_req;
    logic [2:0] src_data0;
    logic [2:0] src_data1;
    logic [1:0] grant;
    logic [1:0] done;
    logic [1:0] err;
    logic       request;
    logic       ack;
    logic [2:0] data_out;
    logic       valid;

    link_arbiter #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_req   (src_req),
        .src_data0 (src_data0),
        .src_data1 (src_data1),
        .grant     (grant),
        .done      (done),
        .err       (err),
        .request   (request),
        .ack       (ack),
        .data_out  (data_out),
        .valid     (valid)
    );

    typedef struct {
        logic [5:0] gde;
        logic [2:0] data;
    } ev_t;

    typedef enum int {M_NORMAL, M_NOACK, M_FORCE} slave_mode_t;

    ev_t         sb_q[$];
    slave_mode_t mode;
    int          n_checks;
    int          n_fail;
    int          cyc;
    int          ack_rise_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void expect_ev(input logic [1:0] g, input logic [1:0] d,
                                      input logic [1:0] e, input logic [2:0] data);
        ev_t ev;
        ev.gde  = {g, d, e};
        ev.data = data;
        sb_q.push_back(ev);
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Slave: raises ack after 5 sampled cycles of request, drops it once valid is seen.
    initial begin
        int rq_cnt;
        rq_cnt       = 0;
        ack          = 1'b0;
        ack_rise_cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || mode == M_NOACK) begin
                ack    = 1'b0;
                rq_cnt = 0;
            end else if (mode == M_FORCE) begin
                ack = 1'b1;
            end else begin
                if (request && !ack) begin
                    rq_cnt++;
                    if (rq_cnt == 5) begin
                        ack          = 1'b1;
                        ack_rise_cyc = cyc;
                        rq_cnt       = 0;
                    end
                end else if (!request) begin
                    rq_cnt = 0;
                end
                if (ack && valid) ack = 1'b0;
                else if (!request && !valid) ack = 1'b0;
            end
        end
    end

    initial begin
        logic prev_valid;
        logic [5:0] obs;
        ev_t ev;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                obs = {grant, done, err};
                if (obs != 6'b0) begin
                    check("pulse_exclusive", 32'($countones(obs) == 1), 32'd1);
                    if (sb_q.size() == 0) begin
                        check("unexpected_event", 32'(obs), 32'd0);
                    end else begin
                        ev = sb_q.pop_front();
                        check("event_kind", 32'(obs), 32'(ev.gde));
                        check("event_data", 32'(data_out), 32'(ev.data));
                    end
                end
                if (valid && !prev_valid)
                    check("valid_after_ack", 32'((cyc - ack_rise_cyc) >= 2), 32'd1);
                prev_valid = valid;
            end else begin
                prev_valid = 1'b0;
            end
        end
    end

    task automatic wait_grant(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant == 2'b00 && n < 60);
        if (grant == 2'b00) check(tag, 32'd0, 32'd1);
    endtask

    task automatic wait_empty(input string tag);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check(tag, 32'({request, valid, grant, done, err, data_out}), 32'd0);
    endtask

    initial begin
        int n;
        int grants;
        mode      = M_NORMAL;
        rst_n     = 1'b0;
        src_req   = 2'b00;
        src_data0 = 3'd0;
        src_data1 = 3'd0;
        n_checks  = 0;
        n_fail    = 0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_outputs");

        // Single source, payload changed after grant must not leak into the transfer.
        src_req   = 2'b01;
        src_data0 = 3'd5;
        expect_ev(2'b01, 2'b00, 2'b00, 3'd5);
        expect_ev(2'b00, 2'b01, 2'b00, 3'd5);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("no_grant_first_edge", 32'(grant), 32'd0);
        wait_grant("grant_timeout_s1");
        check("request_at_grant", 32'(request), 32'd1);
        src_data0 = 3'd2;
        src_req   = 2'b00;
        wait_empty("drain_s1");
        repeat (2) @(negedge clk);
        check("data_hold_after_done", 32'(data_out), 32'd5);

        // Both held after reset: 0, 1, 0.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        src_req   = 2'b11;
        src_data0 = 3'd3;
        src_data1 = 3'd6;
        expect_ev(2'b01, 2'b00, 2'b00, 3'd3);
        expect_ev(2'b00, 2'b01, 2'b00, 3'd3);
        expect_ev(2'b10, 2'b00, 2'b00, 3'd6);
        expect_ev(2'b00, 2'b10, 2'b00, 3'd6);
        expect_ev(2'b01, 2'b00, 2'b00, 3'd3);
        expect_ev(2'b00, 2'b01, 2'b00, 3'd3);
        grants = 0;
        for (int i = 0; i < 3; i++) begin
            wait_grant("grant_timeout_s2");
            if (grant != 2'b00) grants++;
        end
        src_req = 2'b00;
        check("rr_grant_count", 32'(grants), 32'd3);
        wait_empty("drain_s2");

        // Silent slave: request high for 16 cycles then err.
        mode      = M_NOACK;
        src_req   = 2'b10;
        src_data1 = 3'd4;
        expect_ev(2'b10, 2'b00, 2'b00, 3'd4);
        expect_ev(2'b00, 2'b00, 2'b10, 3'd4);
        wait_grant("grant_timeout_s3");
        src_req = 2'b00;
        n = 0;
        while (request && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("timeout_request_cycles", 32'(n), 32'd16);
        check("timeout_link_idle", 32'({request, valid}), 32'd0);
        wait_empty("drain_s3");
        repeat (3) @(negedge clk);
        check("timeout_no_restart", 32'(request), 32'd0);

        // Stale ack: nothing granted until ack drops.
        mode = M_FORCE;
        repeat (5) @(negedge clk);
        src_req   = 2'b01;
        src_data0 = 3'd1;
        grants    = 0;
        repeat (10) begin
            @(negedge clk);
            if (grant != 2'b00) grants++;
        end
        check("stale_ack_no_grant", 32'(grants), 32'd0);
        expect_ev(2'b01, 2'b00, 2'b00, 3'd1);
        expect_ev(2'b00, 2'b01, 2'b00, 3'd1);
        mode = M_NORMAL;
        wait_grant("grant_timeout_s4");
        src_req = 2'b00;
        wait_empty("drain_s4");

        // Reset during SEND, then a clean tie won by source 0.
        src_req   = 2'b01;
        src_data0 = 3'd7;
        expect_ev(2'b01, 2'b00, 2'b00, 3'd7);
        wait_grant("grant_timeout_s5");
        src_req = 2'b00;
        n = 0;
        while (!valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("reached_send", 32'(valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("async_reset_outputs");
        check("reset_queue_empty", 32'(sb_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        src_req   = 2'b11;
        src_data0 = 3'd3;
        src_data1 = 3'd6;
        expect_ev(2'b01, 2'b00, 2'b00, 3'd3);
        expect_ev(2'b00, 2'b01, 2'b00, 3'd3);
        wait_grant("grant_timeout_s5b");
        src_req = 2'b00;
        wait_empty("drain_s5");
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
